// File: rtl/des_core.sv
// des_core: fully pipelined 16-round DES, one block per clock, fixed 16-cycle latency
module des_core (
  output logic [63:0] ciphertext,
  input  logic [63:0] plaintext,
  input  logic [55:0] key,
  input  logic        decrypt,
  input  logic        clk,
  input  logic        reset
);
  localparam int ip_tab [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};
  localparam int fp_tab [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41,  9, 49, 17, 57, 25};
  localparam int e_tab [48] = '{
    32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,  8,  9, 10, 11,
    12, 13, 12, 13, 14, 15, 16, 17, 16, 17, 18, 19, 20, 21, 20, 21,
    22, 23, 24, 25, 24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};
  localparam int p_tab [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};
  localparam int pc1_tab [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
  localparam int pc2_tab [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
  localparam int shift_tab [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
  localparam int sbox_tab [512] = '{
    14,  4, 13,  1,  2, 15, 11,  8,  3, 10,  6, 12,  5,  9,  0,  7,
     0, 15,  7,  4, 14,  2, 13,  1, 10,  6, 12, 11,  9,  5,  3,  8,
     4,  1, 14,  8, 13,  6,  2, 11, 15, 12,  9,  7,  3, 10,  5,  0,
    15, 12,  8,  2,  4,  9,  1,  7,  5, 11,  3, 14, 10,  0,  6, 13,
    15,  1,  8, 14,  6, 11,  3,  4,  9,  7,  2, 13, 12,  0,  5, 10,
     3, 13,  4,  7, 15,  2,  8, 14, 12,  0,  1, 10,  6,  9, 11,  5,
     0, 14,  7, 11, 10,  4, 13,  1,  5,  8, 12,  6,  9,  3,  2, 15,
    13,  8, 10,  1,  3, 15,  4,  2, 11,  6,  7, 12,  0,  5, 14,  9,
    10,  0,  9, 14,  6,  3, 15,  5,  1, 13, 12,  7, 11,  4,  2,  8,
    13,  7,  0,  9,  3,  4,  6, 10,  2,  8,  5, 14, 12, 11, 15,  1,
    13,  6,  4,  9,  8, 15,  3,  0, 11,  1,  2, 12,  5, 10, 14,  7,
     1, 10, 13,  0,  6,  9,  8,  7,  4, 15, 14,  3, 11,  5,  2, 12,
     7, 13, 14,  3,  0,  6,  9, 10,  1,  2,  8,  5, 11, 12,  4, 15,
    13,  8, 11,  5,  6, 15,  0,  3,  4,  7,  2, 12,  1, 10, 14,  9,
    10,  6,  9,  0, 12, 11,  7, 13, 15,  1,  3, 14,  5,  2,  8,  4,
     3, 15,  0,  6, 10,  1, 13,  8,  9,  4,  5, 11, 12,  7,  2, 14,
     2, 12,  4,  1,  7, 10, 11,  6,  8,  5,  3, 15, 13,  0, 14,  9,
    14, 11,  2, 12,  4,  7, 13,  1,  5,  0, 15, 10,  3,  9,  8,  6,
     4,  2,  1, 11, 10, 13,  7,  8, 15,  9, 12,  5,  6,  3,  0, 14,
    11,  8, 12,  7,  1, 14,  2, 13,  6, 15,  0,  9, 10,  4,  5,  3,
    12,  1, 10, 15,  9,  2,  6,  8,  0, 13,  3,  4, 14,  7,  5, 11,
    10, 15,  4,  2,  7, 12,  9,  5,  6,  1, 13, 14,  0, 11,  3,  8,
     9, 14, 15,  5,  2,  8, 12,  3,  7,  0,  4, 10,  1, 13, 11,  6,
     4,  3,  2, 12,  9,  5, 15, 10, 11, 14,  1,  7,  6,  0,  8, 13,
     4, 11,  2, 14, 15,  0,  8, 13,  3, 12,  9,  7,  5, 10,  6,  1,
    13,  0, 11,  7,  4,  9,  1, 10, 14,  3,  5, 12,  2, 15,  8,  6,
     1,  4, 11, 13, 12,  3,  7, 14, 10, 15,  6,  8,  0,  5,  9,  2,
     6, 11, 13,  8,  1,  4, 10,  7,  9,  5,  0, 15, 14,  2,  3, 12,
    13,  2,  8,  4,  6, 15, 11,  1, 10,  9,  3, 14,  5,  0, 12,  7,
     1, 15, 13,  8, 10,  3,  7,  4, 12,  5,  6, 11,  0, 14,  9,  2,
     7, 11,  4,  1,  9, 12, 14,  2,  0,  6, 10, 13, 15,  3,  5,  8,
     2,  1, 14,  7,  4, 10,  8, 13, 15, 12,  9,  0,  3,  5,  6, 11};

  // Tables use FIPS numbering: entry t selects input bit t counted from the MSB.
  function automatic logic [63:0] f_ip(input logic [63:0] x);
    logic [63:0] y;
    for (int j = 0; j < 64; j++) y[6'(63 - j)] = x[6'(64 - ip_tab[6'(j)])];
    return y;
  endfunction

  function automatic logic [63:0] f_fp(input logic [63:0] x);
    logic [63:0] y;
    for (int j = 0; j < 64; j++) y[6'(63 - j)] = x[6'(64 - fp_tab[6'(j)])];
    return y;
  endfunction

  function automatic logic [55:0] f_pc1(input logic [63:0] x);
    logic [55:0] y;
    for (int j = 0; j < 56; j++) y[6'(55 - j)] = x[6'(64 - pc1_tab[6'(j)])];
    return y;
  endfunction

  function automatic logic [47:0] f_pc2(input logic [55:0] x);
    logic [47:0] y;
    for (int j = 0; j < 48; j++) y[6'(47 - j)] = x[6'(56 - pc2_tab[6'(j)])];
    return y;
  endfunction

  function automatic logic [47:0] f_e(input logic [31:0] x);
    logic [47:0] y;
    for (int j = 0; j < 48; j++) y[6'(47 - j)] = x[5'(32 - e_tab[6'(j)])];
    return y;
  endfunction

  function automatic logic [31:0] f_p(input logic [31:0] x);
    logic [31:0] y;
    for (int j = 0; j < 32; j++) y[5'(31 - j)] = x[5'(32 - p_tab[5'(j)])];
    return y;
  endfunction

  function automatic logic [31:0] f_s(input logic [47:0] x);
    logic [31:0] y;
    logic [5:0] six;
    for (int b = 0; b < 8; b++) begin
      six = x[6'(47 - 6 * b) -: 6];
      y[5'(31 - 4 * b) -: 4] = 4'(sbox_tab[{3'(b), six[5], six[0], six[4:1]}]);
    end
    return y;
  endfunction

  function automatic logic [27:0] rotl(input logic [27:0] x, input logic [1:0] n);
    return n == 2'd2 ? {x[25:0], x[27:26]} : n == 2'd1 ? {x[26:0], x[27]} : x;
  endfunction

  function automatic logic [27:0] rotr(input logic [27:0] x, input logic [1:0] n);
    return n == 2'd2 ? {x[1:0], x[27:2]} : n == 2'd1 ? {x[0], x[27:1]} : x;
  endfunction

  logic [31:0] w_l   [17];
  logic [31:0] w_r   [17];
  logic [27:0] w_c   [17];
  logic [27:0] w_d   [17];
  logic        w_dec [17];
  logic [63:0] w_ip;
  logic [63:0] w_kx;
  logic [55:0] w_pc1;

  for (genvar g = 0; g < 8; g++) begin : g_kx
    assign w_kx[63 - 8 * g -: 8] = {key[55 - 7 * g -: 7], 1'b0};
  end

  assign w_ip     = f_ip(plaintext);
  assign w_pc1    = f_pc1(w_kx);
  assign w_l[0]   = w_ip[63:32];
  assign w_r[0]   = w_ip[31:0];
  assign w_c[0]   = w_pc1[55:28];
  assign w_d[0]   = w_pc1[27:0];
  assign w_dec[0] = decrypt;

  // Decryption walks the key schedule backwards: no shift in round 1, then right rotations.
  for (genvar k = 1; k <= 16; k++) begin : g_round
    localparam logic [1:0] sh_e = 2'(shift_tab[k - 1]);
    localparam logic [1:0] sh_d = k == 1 ? 2'd0 : 2'(shift_tab[(17 - k) % 16]);
    logic [27:0] w_cn, w_dn;
    logic [31:0] w_f;
    logic [31:0] r_l, r_r;
    logic [27:0] r_c, r_d;
    logic        r_dec;
    assign w_cn = w_dec[k - 1] ? rotr(w_c[k - 1], sh_d) : rotl(w_c[k - 1], sh_e);
    assign w_dn = w_dec[k - 1] ? rotr(w_d[k - 1], sh_d) : rotl(w_d[k - 1], sh_e);
    assign w_f  = f_p(f_s(f_e(w_r[k - 1]) ^ f_pc2({w_cn, w_dn})));
    always_ff @(posedge clk) begin
      if (reset) begin
        r_l   <= '0;
        r_r   <= '0;
        r_c   <= '0;
        r_d   <= '0;
        r_dec <= 1'b0;
      end else begin
        r_l   <= w_r[k - 1];
        r_r   <= w_l[k - 1] ^ w_f;
        r_c   <= w_cn;
        r_d   <= w_dn;
        r_dec <= w_dec[k - 1];
      end
    end
    assign w_l[k]   = r_l;
    assign w_r[k]   = r_r;
    assign w_c[k]   = r_c;
    assign w_d[k]   = r_d;
    assign w_dec[k] = r_dec;
  end

  assign ciphertext = f_fp({w_r[16], w_l[16]});
endmodule

// File: tb/tb_des_core.sv
// tb_des_core: scoreboard bench for des_core against an independent DES model
module tb_des_core;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        decrypt = 1'b0;
  logic [63:0] plaintext = '0;
  logic [55:0] key = '0;
  logic [63:0] ciphertext;
  int checks = 0;
  int failures = 0;

  des_core dut (
    .ciphertext(ciphertext),
    .plaintext (plaintext),
    .key       (key),
    .decrypt   (decrypt),
    .clk       (clk),
    .reset     (reset)
  );

  always #5 clk = ~clk;

  localparam int ip_t [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};
  localparam int fp_t [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41,  9, 49, 17, 57, 25};
  localparam int e_t [48] = '{
    32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,  8,  9, 10, 11,
    12, 13, 12, 13, 14, 15, 16, 17, 16, 17, 18, 19, 20, 21, 20, 21,
    22, 23, 24, 25, 24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};
  localparam int p_t [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};
  localparam int pc1_t [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
  localparam int pc2_t [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
  localparam int sh_t [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
  localparam int sbox_t [512] = '{
    14,  4, 13,  1,  2, 15, 11,  8,  3, 10,  6, 12,  5,  9,  0,  7,
     0, 15,  7,  4, 14,  2, 13,  1, 10,  6, 12, 11,  9,  5,  3,  8,
     4,  1, 14,  8, 13,  6,  2, 11, 15, 12,  9,  7,  3, 10,  5,  0,
    15, 12,  8,  2,  4,  9,  1,  7,  5, 11,  3, 14, 10,  0,  6, 13,
    15,  1,  8, 14,  6, 11,  3,  4,  9,  7,  2, 13, 12,  0,  5, 10,
     3, 13,  4,  7, 15,  2,  8, 14, 12,  0,  1, 10,  6,  9, 11,  5,
     0, 14,  7, 11, 10,  4, 13,  1,  5,  8, 12,  6,  9,  3,  2, 15,
    13,  8, 10,  1,  3, 15,  4,  2, 11,  6,  7, 12,  0,  5, 14,  9,
    10,  0,  9, 14,  6,  3, 15,  5,  1, 13, 12,  7, 11,  4,  2,  8,
    13,  7,  0,  9,  3,  4,  6, 10,  2,  8,  5, 14, 12, 11, 15,  1,
    13,  6,  4,  9,  8, 15,  3,  0, 11,  1,  2, 12,  5, 10, 14,  7,
     1, 10, 13,  0,  6,  9,  8,  7,  4, 15, 14,  3, 11,  5,  2, 12,
     7, 13, 14,  3,  0,  6,  9, 10,  1,  2,  8,  5, 11, 12,  4, 15,
    13,  8, 11,  5,  6, 15,  0,  3,  4,  7,  2, 12,  1, 10, 14,  9,
    10,  6,  9,  0, 12, 11,  7, 13, 15,  1,  3, 14,  5,  2,  8,  4,
     3, 15,  0,  6, 10,  1, 13,  8,  9,  4,  5, 11, 12,  7,  2, 14,
     2, 12,  4,  1,  7, 10, 11,  6,  8,  5,  3, 15, 13,  0, 14,  9,
    14, 11,  2, 12,  4,  7, 13,  1,  5,  0, 15, 10,  3,  9,  8,  6,
     4,  2,  1, 11, 10, 13,  7,  8, 15,  9, 12,  5,  6,  3,  0, 14,
    11,  8, 12,  7,  1, 14,  2, 13,  6, 15,  0,  9, 10,  4,  5,  3,
    12,  1, 10, 15,  9,  2,  6,  8,  0, 13,  3,  4, 14,  7,  5, 11,
    10, 15,  4,  2,  7, 12,  9,  5,  6,  1, 13, 14,  0, 11,  3,  8,
     9, 14, 15,  5,  2,  8, 12,  3,  7,  0,  4, 10,  1, 13, 11,  6,
     4,  3,  2, 12,  9,  5, 15, 10, 11, 14,  1,  7,  6,  0,  8, 13,
     4, 11,  2, 14, 15,  0,  8, 13,  3, 12,  9,  7,  5, 10,  6,  1,
    13,  0, 11,  7,  4,  9,  1, 10, 14,  3,  5, 12,  2, 15,  8,  6,
     1,  4, 11, 13, 12,  3,  7, 14, 10, 15,  6,  8,  0,  5,  9,  2,
     6, 11, 13,  8,  1,  4, 10,  7,  9,  5,  0, 15, 14,  2,  3, 12,
    13,  2,  8,  4,  6, 15, 11,  1, 10,  9,  3, 14,  5,  0, 12,  7,
     1, 15, 13,  8, 10,  3,  7,  4, 12,  5,  6, 11,  0, 14,  9,  2,
     7, 11,  4,  1,  9, 12, 14,  2,  0,  6, 10, 13, 15,  3,  5,  8,
     2,  1, 14,  7,  4, 10,  8, 13, 15, 12,  9,  0,  3,  5,  6, 11};

  function automatic int tab(int sel, int j);
    case (sel)
      0:       return ip_t[6'(j)];
      1:       return fp_t[6'(j)];
      2:       return e_t[6'(j)];
      3:       return p_t[5'(j)];
      4:       return pc1_t[6'(j)];
      default: return pc2_t[6'(j)];
    endcase
  endfunction

  function automatic logic [63:0] perm(logic [63:0] x, int in_w, int out_w, int sel);
    logic [63:0] y = '0;
    for (int j = 0; j < out_w; j++) y[6'(out_w - 1 - j)] = x[6'(in_w - tab(sel, j))];
    return y;
  endfunction

  // Textbook form: precompute K1..K16, decrypt by consuming them in reverse order.
  function automatic logic [63:0] des_model(logic [55:0] k, logic [63:0] p, logic d);
    logic [63:0] kx, t64;
    logic [47:0] sk [16];
    logic [27:0] c, dd;
    logic [31:0] l, r, f, tmp;
    logic [47:0] x;
    logic [5:0]  six;
    for (int i = 0; i < 64; i++)
      kx[6'(63 - i)] = (i % 8 == 7) ? 1'b0 : k[6'(55 - (i / 8) * 7 - i % 8)];
    t64 = perm(kx, 64, 56, 4);
    c = t64[55:28];
    dd = t64[27:0];
    for (int i = 0; i < 16; i++) begin
      for (int s = 0; s < sh_t[4'(i)]; s++) begin
        c = {c[26:0], c[27]};
        dd = {dd[26:0], dd[27]};
      end
      t64 = perm({8'h0, c, dd}, 56, 48, 5);
      sk[4'(i)] = t64[47:0];
    end
    t64 = perm(p, 64, 64, 0);
    l = t64[63:32];
    r = t64[31:0];
    for (int i = 0; i < 16; i++) begin
      t64 = perm({32'h0, r}, 32, 48, 2);
      x = t64[47:0] ^ sk[d ? 4'(15 - i) : 4'(i)];
      f = '0;
      for (int s = 0; s < 8; s++) begin
        six = x[6'(47 - 6 * s) -: 6];
        f = {f[27:0], 4'(sbox_t[9'(s * 64 + {six[5], six[0]} * 16 + six[4:1])])};
      end
      t64 = perm({32'h0, f}, 32, 32, 3);
      tmp = r;
      r = l ^ t64[31:0];
      l = tmp;
    end
    return perm({r, l}, 64, 64, 1);
  endfunction

  typedef struct {
    logic        v;
    logic [63:0] exp;
    string       name;
  } sb_t;

  typedef struct {
    logic [55:0] k;
    logic [63:0] p;
    logic        d;
    logic [63:0] exp;
    string       name;
  } vec_t;

  sb_t         sb [$];
  logic [63:0] stale [$];
  vec_t        vecs [6];

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock: compare the result due now, then drive and record the next input.
  task automatic step(logic [55:0] k, logic [63:0] p, logic d, logic v, logic [63:0] e, string name);
    sb_t x;
    @(negedge clk);
    if (sb.size() == 16) begin
      x = sb.pop_front();
      if (x.v) check(x.name, ciphertext, x.exp);
    end else if (sb.size() < 15 && stale.size() > 0) begin
      checks++;
      foreach (stale[i]) if (ciphertext === stale[i]) begin
        failures++;
        $display("FAIL stale_result: got %h equal to discarded %h", ciphertext, stale[i]);
      end
    end
    key = k;
    plaintext = p;
    decrypt = d;
    sb.push_back('{v, e, name});
    if (sb.size() == 16) stale.delete();
  endtask

  task automatic idle(int n);
    repeat (n) step('0, '0, 1'b0, 1'b0, '0, "idle");
  endtask

  task automatic do_reset(int n);
    @(negedge clk);
    foreach (sb[i]) if (sb[i].v) stale.push_back(sb[i].exp);
    sb.delete();
    reset = 1'b1;
    key = '0;
    plaintext = '0;
    decrypt = 1'b0;
    repeat (n) begin
      @(negedge clk);
      check("reset_zero", ciphertext, 64'h0);
    end
    reset = 1'b0;
  endtask

  initial begin
    logic [63:0] rk, rp, rc;
    logic        rd;
    vecs[0] = '{56'h12695BC9B7B7F8, 64'h0123456789ABCDEF, 1'b0, 64'h85E813540F0AB405, "v1_enc"};
    vecs[1] = '{56'h0, 64'h0, 1'b0, 64'h8CA64DE9C1B123A7, "v2_zero"};
    vecs[2] = '{56'h12695BC9B7B7F8, 64'h85E813540F0AB405, 1'b1, 64'h0123456789ABCDEF, "v3_dec"};
    vecs[3] = '{56'h0, 64'h8CA64DE9C1B123A7, 1'b1, 64'h0, "zero_dec"};
    vecs[4] = '{56'hFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0, 64'h7359B2163E4EDC58, "ones_enc"};
    vecs[5] = '{56'hFFFFFFFFFFFFFF, 64'h7359B2163E4EDC58, 1'b1, 64'hFFFFFFFFFFFFFFFF, "ones_dec"};
    do_reset(3);
    foreach (vecs[i]) step(vecs[i].k, vecs[i].p, vecs[i].d, 1'b1, vecs[i].exp, vecs[i].name);
    idle(16);
    step(vecs[0].k, vecs[0].p, vecs[0].d, 1'b1, vecs[0].exp, "v1_solo");
    idle(16);
    for (int i = 0; i < 3; i++) step(vecs[i].k, vecs[i].p, vecs[i].d, 1'b1, vecs[i].exp, "inflight");
    idle(4);
    do_reset(2);
    step(vecs[0].k, vecs[0].p, vecs[0].d, 1'b1, vecs[0].exp, "v1_after_reset");
    idle(16);
    for (int i = 0; i < 340; i++) begin
      rk = {$urandom(), $urandom()};
      rp = {$urandom(), $urandom()};
      rd = 1'($urandom_range(0, 1));
      step(rk[55:0], rp, rd, 1'b1, des_model(rk[55:0], rp, rd), "random");
      rc = des_model(rk[55:0], rp, 1'b0);
      step(rk[55:0], rp, 1'b0, 1'b1, rc, "rt_enc");
      step(rk[55:0], rc, 1'b1, 1'b1, rp, "rt_dec");
    end
    idle(16);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
